tabla_sweep: RTL and testbench

Sequencer and checker that drives the 3-bit select code into the truth-table blocks (the 2:1, 4:1 and 8:1 implementations of Table 1 and Table 2) and consumes their outputs. Each run walks the select code 0..7, waits a programmable settle time and samples all six table outputs. It builds one 8-bit column signature per table, flags any code where the three implementations disagree, and reports pass/fail against the expected columns. It sits directly upstream (select source) and downstream (output sink) of the table blocks in the lab top level.

---
 rtl/tabla_sweep.sv | 124 ++++++++++++
 tb/tb_tabla_sweep.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tabla_sweep.sv
// tabla_sweep: steps the 3-bit select code 0..7 into the Table 1 / Table 2
// implementations. For each code it waits SETTLE cycles and then samples all
// six table outputs. It builds one 8-bit column signature per table, flags
// codes where the 2:1, 4:1 and 8:1 implementations disagree, and reports a
// pass/fail verdict against the expected columns.
module tabla_sweep #(
  parameter int         SETTLE = 1,      // settle cycles per code, 1..15
  parameter logic [7:0] EXP1   = 8'h96,  // expected Table 1 column
  parameter logic [7:0] EXP2   = 8'h71   // expected Table 2 column
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] sel,
  input  logic [2:0] t1,
  input  logic [2:0] t2,
  output logic       busy,
  output logic       done,
  output logic [7:0] sig1,
  output logic [7:0] sig2,
  output logic [7:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {
    st_idle,
    st_settle,
    st_sample,
    st_finish
  } state_t;

  // The last settle count before the code is sampled.
  localparam logic [3:0] settle_last = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;

  // Column values after the current code's sample has been written in.
  // pass is computed from these so that it includes the code-7 sample.
  logic [7:0] sig1_nx, sig2_nx, mismatch_nx;
  logic       code_bad;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_nx;
  end

  // Next-state decode.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      st_idle:   if (start) state_nx = st_settle;
      st_settle: if (cnt == settle_last) state_nx = st_sample;
      st_sample: state_nx = (sel == 3'd7) ? st_finish : st_settle;
      st_finish: state_nx = st_idle;
      default:   state_nx = st_idle;
    endcase
  end

  // Merge the current code's sample into the running columns.
  always_comb begin
    code_bad      = ((t1 != 3'b000) && (t1 != 3'b111)) ||
                    ((t2 != 3'b000) && (t2 != 3'b111));
    sig1_nx       = sig1;
    sig2_nx       = sig2;
    mismatch_nx   = mismatch;
    sig1_nx[sel]  = t1[2];
    sig2_nx[sel]  = t2[2];
    mismatch_nx[sel] = code_bad;
  end

  // Select code, settle counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= 3'd0;
      cnt      <= 4'd0;
      sig1     <= 8'h00;
      sig2     <= 8'h00;
      mismatch <= 8'h00;
      pass     <= 1'b0;
    end else begin
      unique case (state)
        st_idle: begin
          if (start) begin
            sel      <= 3'd0;
            cnt      <= 4'd0;
            sig1     <= 8'h00;
            sig2     <= 8'h00;
            mismatch <= 8'h00;
            pass     <= 1'b0;
          end
        end
        st_settle: begin
          if (cnt != settle_last) cnt <= cnt + 4'd1;
        end
        st_sample: begin
          sig1     <= sig1_nx;
          sig2     <= sig2_nx;
          mismatch <= mismatch_nx;
          if (sel == 3'd7) begin
            // Last code: sel parks at 7 and the verdict is registered.
            pass <= (mismatch_nx == 8'h00) && (sig1_nx == EXP1) &&
                    (sig2_nx == EXP2);
          end else begin
            sel <= sel + 3'd1;
            cnt <= 4'd0;
          end
        end
        st_finish: ;
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  assign busy = (state == st_settle) || (state == st_sample);
  assign done = (state == st_finish);

endmodule

// File: tb/tb_tabla_sweep.sv
// Testbench for tabla_sweep. Two instances (SETTLE=1 and SETTLE=3) share the
// clock and reset. The table blocks are emulated from a per-code column plus
// an optional per-implementation fault mask. A behavioural model predicts every
// output from the cycle distance to the accepted start edge, and it is compared
// against both instances on every falling edge.
module tb_tabla_sweep;

  typedef struct packed {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] mi;
    logic       ps;
  } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      start_v;
  logic [1:0][2:0] sel_v, t1_v, t2_v;
  logic [1:0]      busy_v, done_v, pass_v;
  logic [1:0][7:0] sig1_v, sig2_v, mis_v;

  // Emulated tables: column bit per code, xor'd with a per-code fault mask.
  logic [7:0] base1, base2;
  logic [2:0] x1 [8];
  logic [2:0] x2 [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance.
  bit   m_started [2];
  int   m_ec      [2];
  int   m_k0      [2];
  res_t m_res     [2];

  always #5 clk = ~clk;

  tabla_sweep #(.SETTLE(1), .EXP1(8'h96), .EXP2(8'h71)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sel(sel_v[0]),
    .t1(t1_v[0]), .t2(t2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sig1(sig1_v[0]), .sig2(sig2_v[0]), .mismatch(mis_v[0]), .pass(pass_v[0]));

  tabla_sweep #(.SETTLE(3), .EXP1(8'h96), .EXP2(8'h71)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sel(sel_v[1]),
    .t1(t1_v[1]), .t2(t2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sig1(sig1_v[1]), .sig2(sig2_v[1]), .mismatch(mis_v[1]), .pass(pass_v[1]));

  // Combinational table blocks driven by each instance's select code.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      t1_v[i] = {3{base1[sel_v[i]]}} ^ x1[sel_v[i]];
      t2_v[i] = {3{base2[sel_v[i]]}} ^ x2[sel_v[i]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Expected result of a full sweep over the current tables.
  function automatic res_t predict();
    res_t r;
    logic [2:0] v1, v2;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      v1 = {3{base1[c]}} ^ x1[c];
      v2 = {3{base2[c]}} ^ x2[c];
      r.s1[c] = v1[2];
      r.s2[c] = v2[2];
      r.mi[c] = !(v1 == 3'b000 || v1 == 3'b111) || !(v2 == 3'b000 || v2 == 3'b111);
    end
    r.ps = (r.mi == 8'h00) && (r.s1 == 8'h96) && (r.s2 == 8'h71);
    return r;
  endfunction

  // Model: tracks the accepted start edge; a sweep lasts 8*(SETTLE+1) edges,
  // then one FINISH cycle, and only then is start honoured again.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_started[i] <= 1'b0;
        m_ec[i]      <= 0;
        m_k0[i]      <= 0;
        m_res[i]     <= '0;
      end else begin
        if (start_v[i] &&
            (!m_started[i] || (m_ec[i] - m_k0[i]) > 8 * (settle_of(i) + 1))) begin
          m_started[i] <= 1'b1;
          m_k0[i]      <= m_ec[i] + 1;
          m_res[i]     <= predict();
        end
        m_ec[i] <= m_ec[i] + 1;
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         s, t, d, ncap;
      logic       e_busy, e_done, e_pass;
      logic [2:0] e_sel;
      logic [7:0] mask;
      s = settle_of(i);
      t = 8 * (s + 1);
      d = m_ec[i] - m_k0[i];
      if (!m_started[i]) begin
        e_busy = 0; e_done = 0; e_sel = 3'd0; ncap = 0; e_pass = 0;
      end else if (d < t) begin
        e_busy = 1; e_done = 0; e_sel = 3'(d / (s + 1)); ncap = d / (s + 1); e_pass = 0;
      end else begin
        e_busy = 0; e_done = (d == t); e_sel = 3'd7; ncap = 8; e_pass = m_res[i].ps;
      end
      mask = 8'((9'd1 << ncap) - 9'd1);
      if (!m_started[i]) mask = 8'h00;
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(e_busy));
      check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(e_done));
      check($sformatf("sel[%0d]", i),  32'(sel_v[i]),  32'(e_sel));
      check($sformatf("sig1[%0d]", i), 32'(sig1_v[i]), 32'(m_res[i].s1 & mask));
      check($sformatf("sig2[%0d]", i), 32'(sig2_v[i]), 32'(m_res[i].s2 & mask));
      check($sformatf("mis[%0d]", i),  32'(mis_v[i]),  32'(m_res[i].mi & mask));
      check($sformatf("pass[%0d]", i), 32'(pass_v[i]), 32'(e_pass));
    end
  end

  // Raise start so the next rising edge accepts it; return on the falling
  // edge of the first sweep cycle with start low again.
  task automatic launch(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // Count rising edges until done is seen; the bound counts as a failure.
  task automatic wait_done(input int i, input int exp_lat, input string name);
    int n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_v[i]) break;
    end
    check(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic set_tables(input logic [7:0] b1, input logic [7:0] b2);
    base1 = b1;
    base2 = b2;
    for (int c = 0; c < 8; c++) begin
      x1[c] = 3'b000;
      x2[c] = 3'b000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int n;
    rst     = 1'b0;
    start_v = 2'b00;
    set_tables(8'h96, 8'h71);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Correct tables, SETTLE=1.
    launch(0);
    wait_done(0, 16, "lat_correct");
    check("correct_sig1", 32'(sig1_v[0]), 32'h96);
    check("correct_sig2", 32'(sig2_v[0]), 32'h71);
    check("correct_mis",  32'(mis_v[0]),  32'h00);
    check("correct_pass", 32'(pass_v[0]), 32'h1);
    check("correct_sel",  32'(sel_v[0]),  32'h7);
    repeat (3) @(negedge clk);

    // One implementation wrong at code 3.
    x1[3] = 3'b001;
    launch(0);
    wait_done(0, 16, "lat_fault");
    check("fault_mis",  32'(mis_v[0]),  32'h08);
    check("fault_sig1", 32'(sig1_v[0]), 32'h96);
    check("fault_pass", 32'(pass_v[0]), 32'h0);
    repeat (2) @(negedge clk);

    // Consistent but wrong Table 2.
    set_tables(8'h96, 8'h00);
    launch(0);
    wait_done(0, 16, "lat_t2zero");
    check("t2zero_sig2", 32'(sig2_v[0]), 32'h00);
    check("t2zero_mis",  32'(mis_v[0]),  32'h00);
    check("t2zero_pass", 32'(pass_v[0]), 32'h0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a sweep, while sel=4.
    set_tables(8'h96, 8'h71);
    launch(0);
    n = 0;
    while (sel_v[0] != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_sel4", 32'(sel_v[0]), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("rst_sel",  32'(sel_v[0]),  32'h0);
    check("rst_busy", 32'(busy_v[0]), 32'h0);
    check("rst_done", 32'(done_v[0]), 32'h0);
    check("rst_sig1", 32'(sig1_v[0]), 32'h0);
    check("rst_sig2", 32'(sig2_v[0]), 32'h0);
    check("rst_mis",  32'(mis_v[0]),  32'h0);
    check("rst_pass", 32'(pass_v[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(0);
    wait_done(0, 16, "lat_after_rst");
    check("after_rst_pass", 32'(pass_v[0]), 32'h1);
    repeat (2) @(negedge clk);

    // Start pulses during the sweep and in FINISH are ignored.
    launch(0);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_v[0] = (n == 3) || (n == 10);
      if (done_v[0]) break;
    end
    check("lat_ignore", 32'(n), 32'd16);
    start_v[0] = 1'b1;  // high only during the FINISH cycle
    @(negedge clk);
    start_v[0] = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    check("no_second_done", 32'(nd), 32'd0);
    check("idle_busy", 32'(busy_v[0]), 32'h0);

    // Start held through FINISH launches a new sweep from the next IDLE cycle.
    launch(0);
    wait_done(0, 16, "lat_held_first");
    start_v[0] = 1'b1;
    @(negedge clk);  // IDLE cycle, start still high
    check("held_idle_busy", 32'(busy_v[0]), 32'h0);
    @(negedge clk);
    start_v[0] = 1'b0;
    check("held_relaunch_busy", 32'(busy_v[0]), 32'h1);
    wait_done(0, 16, "lat_held_second");
    check("held_pass", 32'(pass_v[0]), 32'h1);
    repeat (2) @(negedge clk);

    // SETTLE=3 instance, correct tables.
    launch(1);
    wait_done(1, 32, "lat_settle3");
    check("settle3_pass", 32'(pass_v[1]), 32'h1);
    check("settle3_sig1", 32'(sig1_v[1]), 32'h96);
    repeat (2) @(negedge clk);

    // Randomized tables and fault masks on both instances.
    for (int it = 0; it < 12; it++) begin
      int k;
      k = it % 2;
      if ($urandom_range(1, 0) == 1) set_tables(8'h96, 8'h71);
      else set_tables(8'($urandom), 8'($urandom));
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(3, 0) == 0) x1[c] = 3'($urandom);
        if ($urandom_range(3, 0) == 0) x2[c] = 3'($urandom);
      end
      launch(k);
      wait_done(k, 8 * (settle_of(k) + 1), $sformatf("lat_rand%0d", it));
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
